// File: rtl/pattern_scan_if.sv
// ---------------------------------------------------------------------------
// pattern_scan_if
// Host-side bundle for pattern_scan_ctrl.
//   master : word producer / configurator (drives start, data_in, cfg_*)
//   slave  : pattern_scan_ctrl (drives status and results)
// Signals:
//   start, data_in      scan request and the word to scan
//   cfg_we, cfg_pattern,
//   cfg_len             runtime pattern configuration
//   busy, done, hit     sequencing status
//   match_cnt,
//   first_pos, found    results of the last scan
//   state_dbg           controller state, for observation only
// Handshake: start is a request that is accepted only on an edge where
// busy is low; the scan then owns the block until the single done pulse,
// and start/cfg_we seen while busy are dropped (never queued).
// ---------------------------------------------------------------------------
interface pattern_scan_if #(
  parameter int WIDTH = 16,
  parameter int PMAX  = 8
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             cfg_we;
  logic [PMAX-1:0]  cfg_pattern;
  logic [CNT_W-1:0] cfg_len;
  logic             busy;
  logic             done;
  logic             hit;
  logic [CNT_W-1:0] match_cnt;
  logic [CNT_W-1:0] first_pos;
  logic             found;
  logic [1:0]       state_dbg;

  modport master (
    output start, data_in, cfg_we, cfg_pattern, cfg_len,
    input  busy, done, hit, match_cnt, first_pos, found, state_dbg
  );

  modport slave (
    input  start, data_in, cfg_we, cfg_pattern, cfg_len,
    output busy, done, hit, match_cnt, first_pos, found, state_dbg
  );
endinterface

// File: rtl/pattern_scan_ctrl.sv
// ---------------------------------------------------------------------------
// pattern_scan_ctrl
// Captures a WIDTH-bit word on an accepted start and shifts it MSB-first,
// one bit per clock, through a runtime-configurable pattern detector.
// Reports the number of matches, the bit index completing the first match
// and a registered per-bit hit pulse.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    pattern_scan_if.slave (start/data_in/cfg_* in; busy/done/hit/
//          match_cnt/first_pos/found/state_dbg out)
// Build option:
//   PSCAN_OVERLAP_EN  defined  : overlapping detection (history kept)
//                     undefined: non-overlapping (history/fill cleared on
//                                a match)
// ---------------------------------------------------------------------------
module pattern_scan_ctrl #(
  parameter int              WIDTH       = 16,
  parameter int              PMAX        = 8,
  parameter logic [PMAX-1:0] DEF_PATTERN = 8'b0000_0110,
  parameter int              DEF_LEN     = 4
) (
  input  logic            clk,
  input  logic            reset,
  pattern_scan_if.slave   bus
);
  localparam int CNT_W  = $clog2(WIDTH + 1);
  localparam int FILL_W = $clog2(PMAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  sh_q, sh_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  // Only PMAX-1 bits are stored: the newest bit comes straight from the
  // shifter MSB, so the full PMAX-bit window is {hist_q, current bit}.
  logic [PMAX-2:0]   hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [PMAX-1:0]   pat_q, pat_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  first_q, first_d;
  logic              found_q, found_d;
  logic              hit_q, hit_d;

  logic [PMAX-1:0]   hist_new;
  logic [FILL_W-1:0] fill_new;
  logic [PMAX-1:0]   len_mask;
  logic              cfg_ok;
  logic              match;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      idx_q   <= '0;
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= DEF_PATTERN;
      len_q   <= CNT_W'(DEF_LEN);
      cnt_q   <= '0;
      first_q <= '0;
      found_q <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      found_q <= found_d;
      hit_q   <= hit_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    idx_d   = idx_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    found_d = found_q;
    hit_d   = 1'b0;

    // Window including the bit consumed on this edge; the match test is
    // made on this updated history, not the registered one.
    hist_new = {hist_q, sh_q[WIDTH-1]};
    fill_new = (fill_q == FILL_W'(PMAX)) ? fill_q : fill_q + FILL_W'(1);

    len_mask = '0;
    for (int i = 0; i < PMAX; i++) begin
      len_mask[i] = (CNT_W'(i) < len_q);
    end

    match  = (CNT_W'(fill_new) >= len_q) &&
             (((hist_new ^ pat_q) & len_mask) == '0);
    cfg_ok = (bus.cfg_len != '0) && (bus.cfg_len <= CNT_W'(PMAX));

    unique case (state_q)
      IDLE: begin
        // Config written on the same edge as start is used by that scan,
        // since the scan only begins reading pat_q/len_q one edge later.
        if (bus.cfg_we && cfg_ok) begin
          pat_d = bus.cfg_pattern;
          len_d = bus.cfg_len;
        end
        if (bus.start) begin
          sh_d    = bus.data_in;
          idx_d   = '0;
          hist_d  = '0;
          fill_d  = '0;
          cnt_d   = '0;
          first_d = '0;
          found_d = 1'b0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        sh_d   = sh_q << 1;
        idx_d  = idx_q + CNT_W'(1);
        hist_d = hist_new[PMAX-2:0];
        fill_d = fill_new;
        if (match) begin
          hit_d = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (!found_q) begin
            first_d = idx_q;
            found_d = 1'b1;
          end
`ifdef PSCAN_OVERLAP_EN
`else
          // Non-overlapping: the next match must be built from fresh bits.
          hist_d = '0;
          fill_d = '0;
`endif
        end
        if (idx_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.hit       = hit_q;
  assign bus.match_cnt = cnt_q;
  assign bus.first_pos = first_q;
  assign bus.found     = found_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
module tb_pattern_scan_ctrl;
  localparam int WIDTH = 16;
  localparam int PMAX  = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);
`ifdef PSCAN_OVERLAP_EN
  localparam bit OV = 1'b1;
`else
  localparam bit OV = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pattern_scan_if #(.WIDTH(WIDTH), .PMAX(PMAX)) bus ();

  pattern_scan_ctrl #(.WIDTH(WIDTH), .PMAX(PMAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard ----------------
  int n_pass;
  int n_total;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic             cfg_we;
    logic [PMAX-1:0]  pat;
    logic [CNT_W-1:0] len;
    logic [WIDTH-1:0] data;
    int               exp_cnt;
    int               exp_first;
  } vec_t;

  vec_t vecs[9];

  // results of one scan
  int done_cyc, done_num, hit_num, first_hit, busy6, busy18;

  // Drives one scan: start accepted on edge 0, then cycles 1..20 are
  // sampled on the falling edge. inj_cyc pulses start+cfg_we (pattern 11,
  // len 2) while busy; rst_cyc pulses reset. -1 disables either.
  task automatic run_scan(input logic [WIDTH-1:0] data, input logic do_cfg,
                          input logic [PMAX-1:0] pat, input logic [CNT_W-1:0] len,
                          input int inj_cyc, input int rst_cyc);
    done_cyc = -1; done_num = 0; hit_num = 0; first_hit = -1;
    busy6 = -1; busy18 = -1;
    @(negedge clk);
    bus.start = 1'b1; bus.data_in = data;
    bus.cfg_we = do_cfg; bus.cfg_pattern = pat; bus.cfg_len = len;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.cfg_we = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (bus.done) begin
        done_num++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (bus.hit) begin
        hit_num++;
        if (first_hit < 0) first_hit = cyc;
      end
      if (cyc == 6)  busy6  = int'(bus.busy);
      if (cyc == 18) busy18 = int'(bus.busy);
      if (cyc == inj_cyc) begin
        bus.start = 1'b1; bus.cfg_we = 1'b1;
        bus.cfg_pattern = 8'b0000_0011; bus.cfg_len = CNT_W'(2);
      end
      if (cyc == rst_cyc) reset = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0; bus.cfg_we = 1'b0; reset = 1'b0;
    end
  endtask

  task automatic check_results(input string tag, input int exp_cnt, input int exp_first);
    chk({tag, " done_cycle"}, done_cyc, WIDTH + 1);
    chk({tag, " done_pulses"}, done_num, 1);
    chk({tag, " busy_c6"}, busy6, 1);
    chk({tag, " busy_c18"}, busy18, 0);
    chk({tag, " match_cnt"}, int'(bus.match_cnt), exp_cnt);
    chk({tag, " first_pos"}, int'(bus.first_pos), exp_first);
    chk({tag, " found"}, int'(bus.found), (exp_cnt != 0) ? 1 : 0);
    chk({tag, " hit_pulses"}, hit_num, exp_cnt);
    chk({tag, " first_hit_cycle"}, first_hit, (exp_cnt != 0) ? exp_first + 2 : -1);
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    reset = 1'b1;
    bus.start = 1'b0; bus.data_in = '0; bus.cfg_we = 1'b0;
    bus.cfg_pattern = '0; bus.cfg_len = '0;

    vecs[0] = '{1'b0, 8'h00, 5'd0, 16'h6000, 1, 3};
    vecs[1] = '{1'b0, 8'h00, 5'd0, 16'h6C00, OV ? 2 : 1, 3};
    vecs[2] = '{1'b1, 8'b0000_0011, 5'd2, 16'hFFFF, OV ? 15 : 8, 1};
    vecs[3] = '{1'b1, 8'b0000_0110, 5'd4, 16'h0000, 0, 0};
    vecs[4] = '{1'b1, 8'h01, 5'd0, 16'h6000, 1, 3};   // len 0: ignored
    vecs[5] = '{1'b1, 8'h01, 5'd9, 16'h6000, 1, 3};   // len > PMAX: ignored
    vecs[6] = '{1'b1, 8'h01, 5'd1, 16'h8001, 2, 0};
    vecs[7] = '{1'b1, 8'hA5, 5'd8, 16'h00A5, 1, 15};
    vecs[8] = '{1'b1, 8'b0000_0110, 5'd4, 16'h6000, 1, 3};

    // T1: reset held two cycles
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst busy", int'(bus.busy), 0);
    chk("rst done", int'(bus.done), 0);
    chk("rst hit", int'(bus.hit), 0);
    chk("rst found", int'(bus.found), 0);
    chk("rst match_cnt", int'(bus.match_cnt), 0);
    chk("rst first_pos", int'(bus.first_pos), 0);
    chk("rst state", int'(bus.state_dbg), 0);

    // Table: config (if any) written on the same edge as start
    for (int v = 0; v < 9; v++) begin
      run_scan(vecs[v].data, vecs[v].cfg_we, vecs[v].pat, vecs[v].len, -1, -1);
      check_results($sformatf("vec%0d", v), vecs[v].exp_cnt, vecs[v].exp_first);
    end

    // T6a: start + cfg_we while busy are dropped
    run_scan(16'h6000, 1'b0, '0, '0, 4, -1);
    check_results("busy_inject", 1, 3);
    // pattern 11/len 2 would give first_pos 2 here if it had been written
    run_scan(16'h6000, 1'b0, '0, '0, -1, -1);
    check_results("after_inject", 1, 3);

    // T6b: reset mid-scan restores defaults and aborts without done
    run_scan(16'hFFFF, 1'b1, 8'b0000_0011, CNT_W'(2), -1, 5);
    chk("midrst busy_c6", busy6, 0);
    chk("midrst done_pulses", done_num, 0);
    chk("midrst match_cnt", int'(bus.match_cnt), 0);
    chk("midrst found", int'(bus.found), 0);
    chk("midrst first_pos", int'(bus.first_pos), 0);
    chk("midrst state", int'(bus.state_dbg), 0);
    run_scan(16'h6000, 1'b0, '0, '0, -1, -1);
    check_results("after_midrst", 1, 3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
